// File: rtl/lut_check_pipe_pkg.sv
// Shared types and helpers for the golden-table checker.
package lut_check_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Number of entries in a truth table over n inputs.
  function automatic int tt_width(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/bit_delay_line.sv
// Single-bit register chain: o_q[0] is i_d delayed one cycle, o_q[k] one more per stage.
module bit_delay_line #(
  parameter int DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_d,
  output logic [DEPTH-1:0] o_q
);

  logic [DEPTH-1:0] r_q;

  // Shift every cycle; synchronous clear to zero.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else begin
      r_q[0] <= i_d;
      for (int k = 1; k < DEPTH; k++) r_q[k] <= r_q[k-1];
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/lut_check_pipe.sv
// Golden-table checker for an N_IN-input boolean function, with error statistics,
// a delayed copy of the FUT result and an exhaustive self-test sweep.
module lut_check_pipe
  import lut_check_pkg::*;
#(
  parameter int N_IN        = 3,
  parameter     TRUTH_TABLE = 8'b00111001,
  parameter int DEPTH       = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N_IN-1:0]  x_in,
  input  logic             valid_in,
  input  logic             z_in,
  input  logic             start,
  input  logic             clr,
  output logic [N_IN-1:0]  x_drv,
  output logic             z_exp,
  output logic             error,
  output logic [DEPTH-1:0] z_pipe,
  output logic [DEPTH-1:0] v_pipe,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_sticky,
  output logic [N_IN-1:0]  first_err_x,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  localparam int TT_W = tt_width(N_IN);

  // Reject a golden table whose width does not cover every input code.
  if ($bits(TRUTH_TABLE) != TT_W) begin : g_tt_width_chk
    $error("lut_check_pipe: TRUTH_TABLE width must be 2**N_IN");
  end
  if (N_IN < 1 || N_IN > 8 || DEPTH < 1) begin : g_param_chk
    $error("lut_check_pipe: N_IN must be 1..8 and DEPTH >= 1");
  end

  localparam logic [TT_W-1:0] TT = TRUTH_TABLE;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [N_IN-1:0]   r_sweep_x;
  logic [CNT_W-1:0]  r_err_cnt;
  logic              r_err_sticky;
  logic [N_IN-1:0]   r_first_err_x;
  logic              r_pass;

  logic w_sweep;
  logic w_last;
  logic w_check_en;
  logic w_start;
  logic w_clear;

  assign w_sweep    = (r_state == SWEEP);
  assign w_last     = w_sweep && (r_sweep_x == {N_IN{1'b1}});
  assign x_drv      = w_sweep ? r_sweep_x : x_in;
  assign z_exp      = TT[x_drv];
  assign w_check_en = w_sweep | valid_in;
  assign error      = w_check_en & (z_in != z_exp);
  // start/clr only act outside the sweep; start also clears statistics.
  assign w_start    = !w_sweep && start;
  assign w_clear    = !w_sweep && (start || clr);

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state: start launches a sweep, the last code ends it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: if (start) w_state_nxt = SWEEP;
      SWEEP:      if (w_last) w_state_nxt = DONE;
      default:    w_state_nxt = IDLE;
    endcase
  end

  // Sweep code counter and end-of-sweep verdict. Statistics were cleared at
  // start and clr is ignored during the sweep, so the sticky flag plus the
  // current cycle's mismatch tells whether any code failed.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_sweep_x <= '0;
      r_pass    <= 1'b0;
    end else if (w_start) begin
      r_sweep_x <= '0;
      r_pass    <= 1'b0;
    end else if (w_sweep) begin
      r_sweep_x <= r_sweep_x + N_IN'(1);
      if (w_last) r_pass <= !(r_err_sticky || error);
    end
  end

  // Error statistics; a clear discards a mismatch in the same cycle.
  always_ff @(posedge clock) begin
    if (!reset_n || w_clear) begin
      r_err_cnt     <= '0;
      r_err_sticky  <= 1'b0;
      r_first_err_x <= '0;
    end else if (error) begin
      if (r_err_cnt != {CNT_W{1'b1}}) r_err_cnt <= r_err_cnt + CNT_W'(1);
      if (!r_err_sticky) r_first_err_x <= x_drv;
      r_err_sticky <= 1'b1;
    end
  end

  bit_delay_line #(.DEPTH(DEPTH)) u_z_dly (
    .i_clk   (clock),
    .i_rst_n (reset_n),
    .i_d     (z_in),
    .o_q     (z_pipe)
  );

  bit_delay_line #(.DEPTH(DEPTH)) u_v_dly (
    .i_clk   (clock),
    .i_rst_n (reset_n),
    .i_d     (w_check_en),
    .o_q     (v_pipe)
  );

  assign err_cnt     = r_err_cnt;
  assign err_sticky  = r_err_sticky;
  assign first_err_x = r_first_err_x;
  assign busy        = w_sweep;
  assign done        = (r_state == DONE);
  assign pass        = r_pass;

endmodule

// File: doc/lut_check_pipe.md
Name: lut_check_pipe

Overview:
Parametrised golden-table checker for an N-input single-output boolean function under test (FUT). Compares the FUT result against a truth-table parameter and raises a combinational mismatch flag. Keeps error statistics and delays the FUT result through a configurable-depth register chain. Adds a self-test sweep FSM that drives every input code to the FUT and reports pass/fail. Sits beside any hand-written combinational function block in the lab designs.

Parameters:
N_IN, 3, number of FUT inputs (1..8)
TRUTH_TABLE, 8'b00111001, golden table, width 2**N_IN; bit i = expected z for x == i
DEPTH, 2, number of z delay stages (>=1)
CNT_W, 8, error counter width

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  synchronous active-low reset
x_in  in  N_IN  external operand (normal mode)
valid_in  in  1  x_in/z_in pair to be checked this cycle (normal mode)
z_in  in  1  FUT output for x_drv, combinational same cycle
start  in  1  one-cycle pulse: begin exhaustive sweep
clr  in  1  one-cycle pulse: clear statistics
x_drv  out  N_IN  operand applied to FUT: sweep counter in SWEEP, else x_in
z_exp  out  1  TRUTH_TABLE[x_drv], combinational
error  out  1  combinational: check_en & (z_in != z_exp)
z_pipe  out  DEPTH  z_pipe[0] = z_in delayed 1 cycle, z_pipe[k] = z_pipe[k-1] delayed 1 cycle
v_pipe  out  DEPTH  check_en delayed alongside z_pipe
err_cnt  out  CNT_W  saturating mismatch count
err_sticky  out  1  set on first mismatch
first_err_x  out  N_IN  x_drv of first mismatch since last clear
busy  out  1  high in SWEEP
done  out  1  high in DONE
pass  out  1  registered at sweep end: 1 iff no mismatch during the sweep

Behaviour:
- Reset (reset_n=0 at posedge): state IDLE; all registered outputs 0; sweep counter 0. Reset wins over start/clr/valid_in, including mid-sweep.
- check_en = (state==SWEEP) | (state!=SWEEP & valid_in).
- Mismatch at posedge: err_cnt += 1, saturating at 2**CNT_W-1; if err_sticky==0 then first_err_x <= x_drv; err_sticky <= 1.
- z_pipe/v_pipe shift every cycle regardless of state; latency from z_in to z_pipe[k] is k+1 cycles.
- FSM states IDLE, SWEEP, DONE:
  - IDLE/DONE + start: clear err_cnt, err_sticky, first_err_x, pass; sweep counter <= 0; -> SWEEP. valid_in in that same cycle is still checked (combinational error visible) but its statistics update is discarded by the clear.
  - SWEEP: x_drv = sweep counter; one code checked per cycle; counter increments. At counter == 2**N_IN-1, after the check: -> DONE; pass <= 1 iff no mismatch in the sweep, including this last code. Sweep lasts exactly 2**N_IN cycles.
  - SWEEP ignores start, clr and valid_in.
  - DONE holds until start; normal checks still update statistics there, but pass is not altered.
- clr in IDLE/DONE: clear err_cnt, err_sticky, first_err_x (not pass). A mismatch in the same cycle as clr is discarded.
- TRUTH_TABLE width must equal 2**N_IN; elaboration error otherwise.

Decomposition:
- Package lut_check_pkg: state enum {IDLE, SWEEP, DONE}; function tt_width(n) = 2**n.
- Sub-module bit_delay_line (parameter DEPTH, synchronous active-low reset) for z_pipe/v_pipe, instantiated twice.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with start=1 -> all outputs 0, busy=0, done=0.
- Normal: valid_in=1, x_in=3, z_in=1 -> error=0. Then x_in=2, z_in=1 -> error=1; next cycle err_cnt=1, err_sticky=1, first_err_x=2. clr -> err_cnt=0, err_sticky=0.
- Sweep with correct model (z_in = TRUTH_TABLE[x_drv]): start -> busy for 8 cycles, x_drv 0..7 -> done=1, pass=1, err_cnt=0.
- Sweep with z_in stuck at 0: mismatches at x=0,3,4,5 -> err_cnt=4, first_err_x=0, pass=0.
- Delay line: DEPTH=2, z_in one-cycle pulse at cycle t -> z_pipe[0]=1 at t+1 only, z_pipe[1]=1 at t+2 only. DEPTH=4 -> z_pipe[3] at t+4.
- Saturation and reset: CNT_W=2 with 5 mismatches -> err_cnt=3. reset_n=0 at sweep cycle 3 -> IDLE and busy=0 at next edge; a following start runs a full 8-cycle sweep.
